// File: rtl/cnn_pkg.sv
// Shared constants for the CNN stages: default frame/arith sizes, FSM encoding
// and row-major 3x3 coefficient indices (k[r][c] = 3r+c).
package cnn_pkg;
    localparam int IMG_W_D  = 28;
    localparam int IMG_H_D  = 28;
    localparam int PIX_W_D  = 8;
    localparam int COEF_W_D = 8;
    localparam int ACC_W_D  = 20;
    localparam int NUM_TAPS = 9;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [3:0] K00 = 4'd0, K01 = 4'd1, K02 = 4'd2;
    localparam logic [3:0] K10 = 4'd3, K11 = 4'd4, K12 = 4'd5;
    localparam logic [3:0] K20 = 4'd6, K21 = 4'd7, K22 = 4'd8;
    localparam logic [3:0] K_LAST = K22;
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel history: read-before-write at the column address, so
// dout is the pixel written one row earlier at the same column.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout
);
    logic [W-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) mem[addr] <= din;
    end
endmodule

// File: rtl/conv3x3_stage.sv
// Streaming 3x3 valid-region convolution with a 2-cycle MAC pipe and frame FSM.
// Optional macro CONV_RELU_EN clamps negative results to zero in the output stage.
module conv3x3_stage
    import cnn_pkg::*;
#(
    parameter int IMG_W  = IMG_W_D,
    parameter int IMG_H  = IMG_H_D,
    parameter int PIX_W  = PIX_W_D,
    parameter int COEF_W = COEF_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              coef_wr,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              done
);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int PRW    = PIX_W + COEF_W + 1;
    localparam int STAGES = 2;

    state_t                         state;
    logic [CW-1:0]                  col;
    logic [RW-1:0]                  row;
    logic [NUM_TAPS-1:0][COEF_W-1:0] coef;
    logic [2:0][2:0][PIX_W-1:0]     win, nwin;
    logic [2:0][PIX_W-1:0]          new_col;
    logic [PIX_W-1:0]               up1, up2;
    logic [NUM_TAPS-1:0][PRW-1:0]   prod_c, prod;
    logic [STAGES:1]                vld_q;
    logic [STAGES:0]                vld_pipe;
    logic signed [ACC_W-1:0]        acc, res;
    logic                           accept, last_pix, tap;

    assign accept   = pix_valid && (state == RUN);
    assign last_pix = accept && (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));
    assign tap      = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign vld_pipe = {vld_q, tap};
    assign out_valid = vld_pipe[STAGES];

    // lb0 holds row r-1, lb1 holds row r-2; lb1 is fed from lb0's old word
    line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
        .clk(clk), .en(accept), .addr(col), .din(pix_in), .dout(up1));
    line_buffer #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
        .clk(clk), .en(accept), .addr(col), .din(up1), .dout(up2));

    // window row 0 is the oldest line, col 2 is the column being accepted now
    always_comb begin
        new_col = {pix_in, up1, up2};
        nwin    = win;
        for (int i = 0; i < 3; i++) begin
            nwin[i][0] = win[i][1];
            nwin[i][1] = win[i][2];
            nwin[i][2] = new_col[i];
        end
    end

    always_comb begin
        prod_c = '0;
        for (int t = 0; t < NUM_TAPS; t++)
            prod_c[t] = PRW'($signed({1'b0, nwin[t/3][t%3]})) * PRW'($signed(coef[t]));
    end

    always_comb begin
        acc = '0;
        for (int t = 0; t < NUM_TAPS; t++)
            acc = acc + ACC_W'($signed(prod[t]));
`ifdef CONV_RELU_EN
        res = acc[ACC_W-1] ? '0 : acc;
`else
        res = acc;
`endif
    end

    always_ff @(posedge clk) begin
        if (accept) win <= nwin;
        prod <= prod_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            out_data <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (vld_pipe[STAGES-1]) out_data <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W-1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) coef <= '0;
        else if (state == IDLE && coef_wr && coef_addr <= K_LAST) coef[coef_addr] <= coef_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (last_pix) state <= FLUSH;
                // leave once only the output stage still holds a result
                FLUSH: if (!(|vld_pipe[STAGES-1:1])) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_stage.sv
// Self-checking bench for conv3x3_stage against a direct 2-D convolution model.
module tb_conv3x3_stage;
    localparam int W = 28, H = 28, ACC_W = 20, NOUT = (W-2)*(H-2);

    logic              clk = 0, rst = 1, go = 0, pix_valid = 0, coef_wr = 0;
    logic [7:0]        pix_in = 0, coef_data = 0;
    logic [3:0]        coef_addr = 0;
    logic              busy, out_valid, done;
    logic [ACC_W-1:0]  out_data;

    conv3x3_stage #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(8), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .go(go), .pix_valid(pix_valid), .pix_in(pix_in),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .busy(busy), .out_valid(out_valid), .out_data(out_data), .done(done));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp = 0, err = 0;
    int kern[9];
    logic [7:0] img[H][W];
    logic [ACC_W-1:0] exp_q[$], got_q[$];
    int done_cnt = 0, first_cyc = -1, p22_cyc = -1;

    always @(negedge clk) begin
        if (out_valid) begin
            if (got_q.size() == 0) first_cyc = cyc;
            got_q.push_back(out_data);
        end
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic void build_expected();
        exp_q.delete();
        for (int i = 0; i < H-2; i++)
            for (int j = 0; j < W-2; j++) begin
                int s = 0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        s += kern[3*a+b] * int'(img[i+a][j+b]);
`ifdef CONV_RELU_EN
                if (s < 0) s = 0;
`endif
                exp_q.push_back(ACC_W'(s));
            end
    endfunction

    function automatic void set_identity();
        foreach (kern[k]) kern[k] = 0;
        kern[4] = 1;
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'((r*28 + c) % 256);
    endfunction

    function automatic void fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'(v);
    endfunction

    task automatic load_coefs();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            coef_wr = 1; coef_addr = 4'(i); coef_data = 8'(kern[i]);
        end
        @(negedge clk);
        coef_wr = 0;
    endtask

    task automatic clear_obs();
        got_q.delete(); done_cnt = 0; first_cyc = -1; p22_cyc = -1;
    endtask

    // gap: 0 none, 1 idle cycle after every pixel, 2 random 0..2 idle cycles
    task automatic drive_frame(input int gap, input int npix, input int inject_at);
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        for (int k = 0; k < npix; k++) begin
            int ng;
            pix_valid = 1;
            pix_in = img[k / W][k % W];
            if (k == W*2 + 2) p22_cyc = cyc;
            if (k == inject_at) begin
                go = 1; coef_wr = 1; coef_addr = 4'd4; coef_data = 8'h55;
            end
            @(negedge clk);
            pix_valid = 0; go = 0; coef_wr = 0;
            ng = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ng; g++) begin
                pix_in = 8'($urandom);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(output bit timed_out);
        int n = 0;
        while (done_cnt == 0 && n < 60) begin
            @(negedge clk); n++;
        end
        timed_out = (done_cnt == 0);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        cmp++; if (out_data !== '0) begin err++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        cmp++; if (done !== 1'b0) begin err++; $display("FAIL reset_done got %b want 0", done); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        bit to;
        set_identity(); fill_ramp(); build_expected(); load_coefs(); clear_obs();
        drive_frame(0, W*H, -1); wait_done(to);
        cmp++; if (to) begin err++; $display("FAIL ident_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL ident_count got %0d want %0d", got_q.size(), NOUT); end
        cmp++; if (done_cnt !== 1) begin err++; $display("FAIL ident_done got %0d want 1", done_cnt); end
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL ident_busy_after got %b want 0", busy); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== exp_q[i]) begin err++; $display("FAIL ident_data[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_ones_const();
        bit to;
        foreach (kern[k]) kern[k] = 1;
        fill_const(255); build_expected(); load_coefs(); clear_obs();
        drive_frame(0, W*H, -1); wait_done(to);
        cmp++; if (to) begin err++; $display("FAIL ones_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL ones_count got %0d want %0d", got_q.size(), NOUT); end
        cmp++; if (first_cyc - p22_cyc !== 2) begin err++; $display("FAIL ones_latency got %0d want 2", first_cyc - p22_cyc); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== ACC_W'(2295)) begin err++; $display("FAIL ones_data[%0d] got %0d want 2295", i, $signed(got_q[i])); end
        end
    endtask

    task automatic test_negative();
        bit to;
        logic [ACC_W-1:0] want;
        foreach (kern[k]) kern[k] = 0;
        kern[4] = -1;
        fill_const(10); build_expected(); load_coefs(); clear_obs();
`ifdef CONV_RELU_EN
        want = '0;
`else
        want = ACC_W'(-10);
`endif
        drive_frame(0, W*H, -1); wait_done(to);
        cmp++; if (to) begin err++; $display("FAIL neg_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL neg_count got %0d want %0d", got_q.size(), NOUT); end
        for (int i = 0; i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== want) begin err++; $display("FAIL neg_data[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(want)); end
        end
    endtask

    task automatic test_gaps();
        bit to;
        set_identity(); fill_ramp(); build_expected(); load_coefs(); clear_obs();
        drive_frame(1, W*H, -1); wait_done(to);
        cmp++; if (to) begin err++; $display("FAIL gaps_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL gaps_count got %0d want %0d", got_q.size(), NOUT); end
        cmp++; if (done_cnt !== 1) begin err++; $display("FAIL gaps_done got %0d want 1", done_cnt); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== exp_q[i]) begin err++; $display("FAIL gaps_data[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_midframe_reset();
        bit to;
        set_identity(); fill_ramp(); build_expected(); load_coefs(); clear_obs();
        drive_frame(0, 100, -1);
        rst = 1;
        @(negedge clk);
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL mrst_busy got %b want 0", busy); end
        cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL mrst_out_valid got %b want 0", out_valid); end
        cmp++; if (done !== 1'b0) begin err++; $display("FAIL mrst_done got %b want 0", done); end
        rst = 0;
        got_q.delete();
        for (int k = 0; k < 20; k++) begin
            pix_valid = 1; pix_in = 8'($urandom);
            @(negedge clk);
        end
        pix_valid = 0;
        repeat (5) @(negedge clk);
        cmp++; if (got_q.size() !== 0) begin err++; $display("FAIL mrst_stray_out got %0d want 0", got_q.size()); end
        cmp++; if (done_cnt !== 0) begin err++; $display("FAIL mrst_stray_done got %0d want 0", done_cnt); end
        load_coefs(); clear_obs();
        drive_frame(0, W*H, -1); wait_done(to);
        cmp++; if (to) begin err++; $display("FAIL mrst_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL mrst_count got %0d want %0d", got_q.size(), NOUT); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== exp_q[i]) begin err++; $display("FAIL mrst_data[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_busy_ignore();
        bit to;
        set_identity(); fill_ramp(); build_expected(); load_coefs(); clear_obs();
        drive_frame(0, W*H, 300); wait_done(to);
        repeat (10) @(negedge clk);
        cmp++; if (to) begin err++; $display("FAIL ign_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL ign_count got %0d want %0d", got_q.size(), NOUT); end
        cmp++; if (done_cnt !== 1) begin err++; $display("FAIL ign_done got %0d want 1", done_cnt); end
        cmp++; if (busy !== 1'b0) begin err++; $display("FAIL ign_second_frame busy got %b want 0", busy); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== exp_q[i]) begin err++; $display("FAIL ign_data[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    task automatic test_random();
        bit to;
        foreach (kern[k]) kern[k] = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
        build_expected(); load_coefs();
        // out-of-range indices must not land on any tap
        for (int a = 9; a < 16; a++) begin
            @(negedge clk);
            coef_wr = 1; coef_addr = 4'(a); coef_data = 8'($urandom);
        end
        @(negedge clk); coef_wr = 0;
        clear_obs();
        drive_frame(2, W*H, -1); wait_done(to);
        cmp++; if (to) begin err++; $display("FAIL rand_timeout no done pulse"); end
        cmp++; if (got_q.size() !== NOUT) begin err++; $display("FAIL rand_count got %0d want %0d", got_q.size(), NOUT); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            cmp++; if (got_q[i] !== exp_q[i]) begin err++; $display("FAIL rand_data[%0d] got %0d want %0d", i, $signed(got_q[i]), $signed(exp_q[i])); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ones_const();
        test_negative();
        test_gaps();
        test_midframe_reset();
        test_busy_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
